// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_AW   = 5;
    localparam int NSRC    = 2;

    localparam logic [WB_AW-1:0] REG_X0 = 5'd0;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;

    typedef struct packed {
        logic               valid;
        logic [WB_AW-1:0]   rd;
        logic [WB_XLEN-1:0] data;
    } slot_t;

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_MEM = 1'b1
    } ptr_t;

    function automatic logic is_x0(input logic [WB_AW-1:0] rd);
        return rd == REG_X0;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes and register-file write port of the write-back block.
// The forwarding signals exist only when WB_BYPASS_EN is defined.
interface regfile_writeback_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            s0_valid;
    logic            s0_ready;
    logic [AW-1:0]   s0_rd;
    logic [XLEN-1:0] s0_data;
    logic            s1_valid;
    logic            s1_ready;
    logic [AW-1:0]   s1_rd;
    logic [XLEN-1:0] s1_data;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            idle;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
`endif

    modport master (
        output s0_valid, s0_rd, s0_data, s1_valid, s1_rd, s1_data,
`ifdef WB_BYPASS_EN
        output rs1_addr, rs2_addr,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
`endif
        input  s0_ready, s1_ready, rf_we, rf_waddr, rf_wdata, idle
    );

    modport slave (
        input  s0_valid, s0_rd, s0_data, s1_valid, s1_rd, s1_data,
`ifdef WB_BYPASS_EN
        input  rs1_addr, rs2_addr,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
`endif
        output s0_ready, s1_ready, rf_we, rf_waddr, rf_wdata, idle
    );

endinterface

// File: rtl/wb_slot.sv
// One-entry result holding register; a granted slot may refill on the same edge it drains.
module wb_slot
    import wb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WB_AW-1:0]   in_rd,
    input  logic [WB_XLEN-1:0] in_data,
    input  logic               grant,
    output logic               ready,
    output slot_t              slot
);

    assign ready = !slot.valid || grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (in_valid && ready) begin
            slot.valid <= 1'b1;
            slot.rd    <= in_rd;
            slot.data  <= in_data;
        end else if (grant) begin
            slot.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back front end: two result slots, round-robin arbiter, registered RF write port.
// Optional operand forwarding from the output stage is enabled by WB_BYPASS_EN.
//
// state   | meaning
// PTR_ALU | ALU slot wins when both slots hold a result
// PTR_MEM | memory slot wins when both slots hold a result
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int AW   = WB_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_writeback_if.slave    wb
);

    logic            src_valid [NSRC];
    logic [AW-1:0]   src_rd    [NSRC];
    logic [XLEN-1:0] src_data  [NSRC];
    logic            src_ready [NSRC];
    slot_t           slot      [NSRC];
    logic [NSRC-1:0] grant;

    ptr_t            ptr_q, ptr_d;
    slot_t           win;
    logic            any_grant;

    logic            rf_we_q;
    logic [AW-1:0]   rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    assign src_valid[SRC_ALU] = wb.s0_valid;
    assign src_rd[SRC_ALU]    = wb.s0_rd;
    assign src_data[SRC_ALU]  = wb.s0_data;
    assign src_valid[SRC_MEM] = wb.s1_valid;
    assign src_rd[SRC_MEM]    = wb.s1_rd;
    assign src_data[SRC_MEM]  = wb.s1_data;

    assign wb.s0_ready = src_ready[SRC_ALU];
    assign wb.s1_ready = src_ready[SRC_MEM];

    for (genvar k = 0; k < NSRC; k++) begin : g_slot
        wb_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .in_valid (src_valid[k]),
            .in_rd    (src_rd[k]),
            .in_data  (src_data[k]),
            .grant    (grant[k]),
            .ready    (src_ready[k]),
            .slot     (slot[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PTR_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        case ({slot[SRC_MEM].valid, slot[SRC_ALU].valid})
            2'b01:   grant[SRC_ALU] = 1'b1;
            2'b10:   grant[SRC_MEM] = 1'b1;
            2'b11: begin
                if (ptr_q == PTR_ALU) begin
                    grant[SRC_ALU] = 1'b1;
                end else begin
                    grant[SRC_MEM] = 1'b1;
                end
            end
            default: grant = '0;
        endcase
        // Hand priority to the other source after every grant, including x0 drops.
        if (grant[SRC_ALU]) begin
            ptr_d = PTR_MEM;
        end else if (grant[SRC_MEM]) begin
            ptr_d = PTR_ALU;
        end
    end

    assign any_grant = |grant;
    assign win       = grant[SRC_MEM] ? slot[SRC_MEM] : slot[SRC_ALU];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= any_grant && !is_x0(win.rd);
            if (any_grant) begin
                rf_waddr_q <= win.rd;
                rf_wdata_q <= win.data;
            end
        end
    end

    assign wb.rf_we    = rf_we_q;
    assign wb.rf_waddr = rf_waddr_q;
    assign wb.rf_wdata = rf_wdata_q;
    assign wb.idle     = !slot[SRC_ALU].valid && !slot[SRC_MEM].valid && !rf_we_q;

`ifdef WB_BYPASS_EN
    // Covers the cycle where the RF has not yet captured the staged write.
    logic hit1, hit2;
    assign hit1         = rf_we_q && (wb.rs1_addr == rf_waddr_q) && (wb.rs1_addr != REG_X0);
    assign hit2         = rf_we_q && (wb.rs2_addr == rf_waddr_q) && (wb.rs2_addr != REG_X0);
    assign wb.fwd1_hit  = hit1;
    assign wb.fwd2_hit  = hit2;
    assign wb.fwd1_data = hit1 ? rf_wdata_q : '0;
    assign wb.fwd2_data = hit2 ? rf_wdata_q : '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic against a cycle model.
module tb_regfile_writeback;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_if #(.XLEN(32), .AW(5)) wb ();

    regfile_writeback dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t log_q[$];

    // Reference model state: what each slot holds, priority owner, staged write.
    bit          m_v   [2];
    logic [4:0]  m_rd  [2];
    logic [31:0] m_d   [2];
    int          m_ptr;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          rs_rand = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        if (m_v[0] && m_v[1]) return m_ptr;
        if (m_v[0]) return 0;
        if (m_v[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_v[0] = 0; m_v[1] = 0;
        m_rd[0] = '0; m_rd[1] = '0;
        m_d[0] = '0; m_d[1] = '0;
        m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0;
    endtask

    always @(negedge clk) begin
        int g;
        if (!rst) begin
            g = m_grant();
            check("rf_we", wb.rf_we, m_we);
            check("rf_waddr", wb.rf_waddr, m_addr);
            check("rf_wdata", wb.rf_wdata, m_data);
            check("s0_ready", wb.s0_ready, (!m_v[0] || g == 0));
            check("s1_ready", wb.s1_ready, (!m_v[1] || g == 1));
            check("idle", wb.idle, (!m_v[0] && !m_v[1] && !m_we));
`ifdef WB_BYPASS_EN
            begin
                bit h1, h2;
                h1 = m_we && (wb.rs1_addr == m_addr) && (wb.rs1_addr != 5'd0);
                h2 = m_we && (wb.rs2_addr == m_addr) && (wb.rs2_addr != 5'd0);
                check("fwd1_hit", wb.fwd1_hit, h1);
                check("fwd2_hit", wb.fwd2_hit, h2);
                check("fwd1_data", wb.fwd1_data, h1 ? m_data : 32'd0);
                check("fwd2_data", wb.fwd2_data, h2 ? m_data : 32'd0);
            end
`endif
            if (wb.rf_we === 1'b1) log_q.push_back('{a: wb.rf_waddr, d: wb.rf_wdata});
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                       output bit a0, output bit a1);
        int g;
        bit n_v0, n_v1, n_we;
        int n_ptr;
        #2;
        wb.s0_valid = v0; wb.s0_rd = r0; wb.s0_data = d0;
        wb.s1_valid = v1; wb.s1_rd = r1; wb.s1_data = d1;
`ifdef WB_BYPASS_EN
        if (rs_rand) begin
            wb.rs1_addr = ($urandom_range(0, 1) == 0) ? m_rd[$urandom_range(0, 1)] : 5'($urandom_range(0, 31));
            wb.rs2_addr = ($urandom_range(0, 1) == 0) ? m_rd[$urandom_range(0, 1)] : 5'($urandom_range(0, 31));
        end
`endif
        g  = m_grant();
        a0 = v0 && (!m_v[0] || g == 0);
        a1 = v1 && (!m_v[1] || g == 1);
        n_we = 0; n_ptr = m_ptr;
        if (g >= 0) begin
            n_we  = (m_rd[g] != 5'd0);
            n_ptr = 1 - g;
        end
        n_v0 = a0 ? 1'b1 : ((g == 0) ? 1'b0 : m_v[0]);
        n_v1 = a1 ? 1'b1 : ((g == 1) ? 1'b0 : m_v[1]);
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_addr = m_rd[g];
            m_data = m_d[g];
        end
        m_we = n_we; m_ptr = n_ptr;
        m_v[0] = n_v0; m_v[1] = n_v1;
        if (a0) begin m_rd[0] = r0; m_d[0] = d0; end
        if (a1) begin m_rd[1] = r1; m_d[1] = d1; end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        bit a0, a1;
        for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, a0, a1);
    endtask

    task automatic do_reset(input bit with_checks);
        #2;
        wb.s0_valid = 0; wb.s1_valid = 0;
        rst = 1'b1;
        #1;
        if (with_checks) begin
            check("rst_rf_we", wb.rf_we, 1'b0);
            check("rst_rf_waddr", wb.rf_waddr, 5'd0);
            check("rst_s0_ready", wb.s0_ready, 1'b1);
            check("rst_s1_ready", wb.s1_ready, 1'b1);
            check("rst_idle", wb.idle, 1'b1);
        end
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Feeds two producer queues; each holds its head valid until accepted.
    task automatic stream(input wr_t q0_in[$], input wr_t q1_in[$], output int stall1);
        wr_t q0[$], q1[$];
        bit a0, a1, v0, v1;
        int n;
        q0 = q0_in; q1 = q1_in;
        stall1 = 0;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
            v0 = q0.size() > 0;
            v1 = q1.size() > 0;
            if (v1 && wb.s1_ready !== 1'b1) stall1++;
            cyc(v0, v0 ? q0[0].a : 5'd0, v0 ? q0[0].d : 32'd0,
                v1, v1 ? q1[0].a : 5'd0, v1 ? q1[0].d : 32'd0, a0, a1);
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            n++;
        end
        check("stream_drained", n < 200, 1'b1);
        idle_cycles(4);
    endtask

    task automatic check_log(input string name, input wr_t exp[$]);
        check({name, "_count"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
            check({name, "_addr"}, log_q[i].a, exp[i].a);
            check({name, "_data"}, log_q[i].d, exp[i].d);
        end
    endtask

    initial begin
        bit a0, a1;
        int stall1;
        wr_t q0[$], q1[$], exp[$];

        wb.s0_valid = 0; wb.s0_rd = '0; wb.s0_data = '0;
        wb.s1_valid = 0; wb.s1_rd = '0; wb.s1_data = '0;
`ifdef WB_BYPASS_EN
        wb.rs1_addr = '0; wb.rs2_addr = '0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check("init_rf_we", wb.rf_we, 1'b0);
        check("init_rf_waddr", wb.rf_waddr, 5'd0);
        check("init_rf_wdata", wb.rf_wdata, 32'd0);
        check("init_idle", wb.idle, 1'b1);
        check("init_s0_ready", wb.s0_ready, 1'b1);
        check("init_s1_ready", wb.s1_ready, 1'b1);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single write: accepted at edge N, visible after edge N+1 for one cycle.
        cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, a0, a1);
        check("single_accept", a0, 1'b1);
        check("single_we_early", wb.rf_we, 1'b0);
        idle_cycles(1);
        check("single_we", wb.rf_we, 1'b1);
        check("single_addr", wb.rf_waddr, 5'd5);
        check("single_data", wb.rf_wdata, 32'hDEADBEEF);
        idle_cycles(1);
        check("single_we_off", wb.rf_we, 1'b0);
        check("single_addr_hold", wb.rf_waddr, 5'd5);
        idle_cycles(2);

        // Reset with both slots full and a write staged.
        cyc(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, a0, a1);
        cyc(1, 5'd6, 32'h66, 1, 5'd8, 32'h88, a0, a1);
        check("pre_rst_we", wb.rf_we, 1'b1);
        do_reset(1);

        // Contention right after reset: ALU goes first.
        log_q.delete();
        q0.delete(); q1.delete(); exp.delete();
        for (int i = 1; i <= 4; i++) begin
            q0.push_back('{a: 5'(i), d: 32'hA0 + 32'(i)});
            q1.push_back('{a: 5'(10 + i), d: 32'hB0 + 32'(i)});
            exp.push_back('{a: 5'(i), d: 32'hA0 + 32'(i)});
            exp.push_back('{a: 5'(10 + i), d: 32'hB0 + 32'(i)});
        end
        stream(q0, q1, stall1);
        check_log("contention", exp);

        // x0 result is consumed but never written.
        log_q.delete();
        q0.delete(); q1.delete(); exp.delete();
        q1.push_back('{a: 5'd0, d: 32'h1234});
        q1.push_back('{a: 5'd7, d: 32'h55});
        exp.push_back('{a: 5'd7, d: 32'h55});
        stream(q0, q1, stall1);
        check_log("x0", exp);
        check("x0_s1_stalls", stall1, 0);

        // Back-pressure: 8 vs 8 under constant contention.
        do_reset(0);
        log_q.delete();
        q0.delete(); q1.delete(); exp.delete();
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{a: 5'(1 + i), d: 32'h100 + 32'(i)});
            q1.push_back('{a: 5'(16 + i), d: 32'h200 + 32'(i)});
            exp.push_back('{a: 5'(1 + i), d: 32'h100 + 32'(i)});
            exp.push_back('{a: 5'(16 + i), d: 32'h200 + 32'(i)});
        end
        stream(q0, q1, stall1);
        check_log("backpressure", exp);

`ifdef WB_BYPASS_EN
        rs_rand = 1'b0;
        wb.rs1_addr = 5'd9; wb.rs2_addr = 5'd0;
        cyc(1, 5'd9, 32'hCAFE, 0, 5'd0, 32'd0, a0, a1);
        idle_cycles(1);
        check("byp_hit1", wb.fwd1_hit, 1'b1);
        check("byp_data1", wb.fwd1_data, 32'hCAFE);
        check("byp_hit2_x0", wb.fwd2_hit, 1'b0);
        cyc(0, 5'd0, 32'd0, 1, 5'd0, 32'h77, a0, a1);
        idle_cycles(1);
        check("byp_hit2_w0", wb.fwd2_hit, 1'b0);
        check("byp_data2_w0", wb.fwd2_data, 32'd0);
        rs_rand = 1'b1;
        idle_cycles(2);
`endif

        // Random traffic, including x0 destinations and an async reset midway.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset(1);
            cyc($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 31)), $urandom(),
                $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 31)), $urandom(),
                a0, a1);
        end
        idle_cycles(4);
        check("final_idle", wb.idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
